sha256_pad_ctrl: RTL

Front-end sequencer for the SHA-256 compression core. It accepts the message as a byte stream and applies FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit big-endian bit length. It packs bytes big-endian into 32-bit words and feeds the core 16 words per block. It paces blocks against the core's per-block completion and flags the first and last blocks so the core knows when to load the IV and when to present the digest.

---
 rtl/sha256_pkg.sv | 37 +++
 rtl/sha256_pad_ctrl_if.sv | 39 +++
 rtl/sha256_word_packer.sv | 65 ++++++
 rtl/sha256_pad_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
// Shared types and constants for the SHA-256 padding front-end and the
// compression core it feeds.
//   state_e    : sequencer states of sha256_pad_ctrl
//   word_t     : 32-bit message word handed to the core
//   byte_t     : message / padding byte
//   bitlen_t   : 64-bit message length field (in bits)
//   len_byte() : selects byte idx (0 = most significant) of the length field
// ---------------------------------------------------------------------------
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MSG,
        ST_PAD80,
        ST_ZERO,
        ST_LEN,
        ST_WAITW,
        ST_WAITC,
        ST_DONE
    } state_e;

    typedef logic [31:0] word_t;
    typedef logic [7:0]  byte_t;
    typedef logic [63:0] bitlen_t;

    localparam byte_t      PAD_BYTE      = 8'h80;
    localparam logic [5:0] LEN_POS       = 6'd56;
    localparam int         WORDS_PER_BLK = 16;

    // Length bytes go out most significant first: idx 0 is bits [63:56].
    function automatic byte_t len_byte(input bitlen_t bitlen, input logic [2:0] idx);
        return byte_t'(bitlen >> {~idx, 3'b000});
    endfunction

endpackage

// File: rtl/sha256_pad_ctrl_if.sv
// ---------------------------------------------------------------------------
// sha256_pad_ctrl_if
// Bundles the byte-stream input, the word output towards the core and the
// status flags of sha256_pad_ctrl.
//   master : message source + compression core side (drives bytes, w_ready,
//            core_done; observes everything else)
//   slave  : the padding sequencer itself
// ---------------------------------------------------------------------------
interface sha256_pad_ctrl_if;
    import sha256_pkg::*;

    byte_t in_data;
    logic  in_valid;
    logic  in_last;
    logic  in_nobyte;
    logic  in_ready;

    word_t w_data;
    logic  w_valid;
    logic  w_ready;
    logic  blk_first;
    logic  blk_last;
    logic  core_done;

    logic  busy;
    logic  done;
    logic  len_err;

    modport master (
        output in_data, in_valid, in_last, in_nobyte, w_ready, core_done,
        input  in_ready, w_data, w_valid, blk_first, blk_last, busy, done, len_err
    );

    modport slave (
        input  in_data, in_valid, in_last, in_nobyte, w_ready, core_done,
        output in_ready, w_data, w_valid, blk_first, blk_last, busy, done, len_err
    );

endinterface

// File: rtl/sha256_word_packer.sv
// ---------------------------------------------------------------------------
// sha256_word_packer
// Shifts bytes in big-endian order (first byte ends up in [31:24]) and,
// once four bytes are collected, presents the word with valid/ready.
// While a word is pending further pushes are ignored; the caller is expected
// to stall on w_valid.
//   clk, reset : clock, synchronous active-high reset
//   push       : push_byte is taken this cycle
//   push_byte  : byte to pack
//   w_data     : packed word (stable while w_valid)
//   w_valid    : word pending
//   w_ready    : consumer accepts the pending word
//   xfer       : w_valid & w_ready, word leaves this cycle
// ---------------------------------------------------------------------------
module sha256_word_packer
    import sha256_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  byte_t push_byte,
    input  logic  w_ready,
    output word_t w_data,
    output logic  w_valid,
    output logic  xfer
);

    word_t      sr_q, sr_d;
    logic [1:0] cnt_q, cnt_d;
    logic       full_q, full_d;

    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        if (full_q) begin
            if (w_ready) begin
                full_d = 1'b0;
            end
        end else if (push) begin
            sr_d  = {sr_q[23:0], push_byte};
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign w_data  = sr_q;
    assign w_valid = full_q;
    assign xfer    = full_q & w_ready;

endmodule

// File: rtl/sha256_pad_ctrl.sv
// ---------------------------------------------------------------------------
// sha256_pad_ctrl
// Byte-stream front-end for the SHA-256 compression core. Applies standard
// padding (0x80, zero fill, 64-bit big-endian bit length), packs bytes into
// 32-bit words, sends 16 words per block and waits for the core's per-block
// completion before continuing.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of sha256_pad_ctrl_if
//                in_*          byte stream (in_nobyte marks an empty message)
//                w_*           word stream to the core, blk_first/blk_last
//                core_done     core finished the current block
//                busy/done     message in progress / final block compressed
//                len_err       sticky byte-counter overflow
// Parameter LEN_W: width of the message byte counter.
// ---------------------------------------------------------------------------
module sha256_pad_ctrl
    import sha256_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    sha256_pad_ctrl_if.slave bus
);

    state_e             state_q, state_d;
    state_e             ret_q, ret_d;       // state to resume after a word/block wait
    logic [5:0]         byte_pos_q, byte_pos_d;
    logic [3:0]         word_idx_q, word_idx_d;
    logic [LEN_W-1:0]   msg_len_q, msg_len_d;
    logic               first_q, first_d;
    logic               last_q, last_d;
    logic               len_err_q, len_err_d;

    state_e  nxt;
    logic    push;
    byte_t   push_byte;
    logic    in_rdy;
    word_t   w_data;
    logic    w_valid;
    logic    xfer;
    bitlen_t bitlen;

    assign bitlen = {{(61-LEN_W){1'b0}}, msg_len_q, 3'b000};

    sha256_word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_byte (push_byte),
        .w_ready   (bus.w_ready),
        .w_data    (w_data),
        .w_valid   (w_valid),
        .xfer      (xfer)
    );

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        byte_pos_d = byte_pos_q;
        word_idx_d = word_idx_q;
        msg_len_d  = msg_len_q;
        first_d    = first_q;
        last_d     = last_q;
        len_err_d  = len_err_q;
        nxt        = state_q;
        push       = 1'b0;
        push_byte  = '0;
        in_rdy     = 1'b0;

        case (state_q)
            ST_IDLE, ST_MSG: begin
                in_rdy = !w_valid;
                if (bus.in_valid && in_rdy) begin
                    if (state_q == ST_IDLE) begin
                        first_d   = 1'b1;
                        len_err_d = 1'b0;
                    end
                    nxt = bus.in_last ? ST_PAD80 : ST_MSG;
                    if (bus.in_last && bus.in_nobyte) begin
                        // Empty-message marker: nothing stored or counted.
                        state_d = nxt;
                    end else begin
                        push      = 1'b1;
                        push_byte = bus.in_data;
                        msg_len_d = msg_len_q + LEN_W'(1);
                        if (&msg_len_q) begin
                            len_err_d = 1'b1;
                        end
                    end
                end
            end
            ST_PAD80: begin
                push      = 1'b1;
                push_byte = PAD_BYTE;
                // Length fits behind 0x80 in this block only if 0x80 lands before 56.
                if (byte_pos_q < LEN_POS) begin
                    last_d = 1'b1;
                end
                nxt = (byte_pos_q == LEN_POS - 6'd1) ? ST_LEN : ST_ZERO;
            end
            ST_ZERO: begin
                push      = 1'b1;
                push_byte = 8'h00;
                nxt       = (byte_pos_q == LEN_POS - 6'd1) ? ST_LEN : ST_ZERO;
            end
            ST_LEN: begin
                push      = 1'b1;
                push_byte = len_byte(bitlen, byte_pos_q[2:0]);
                nxt       = ST_LEN;
            end
            ST_WAITW: begin
                if (xfer) begin
                    word_idx_d = word_idx_q + 4'd1;
                    state_d    = (word_idx_q == 4'(WORDS_PER_BLK - 1)) ? ST_WAITC : ret_q;
                end
            end
            ST_WAITC: begin
                if (bus.core_done) begin
                    if (last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ret_q;
                        first_d = 1'b0;
                        // Resuming inside zero fill means 0x80 overflowed the
                        // previous block, so the length lands in this one.
                        if (ret_q == ST_ZERO) begin
                            last_d = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                first_d    = 1'b0;
                last_d     = 1'b0;
                msg_len_d  = '0;
                byte_pos_d = '0;
                word_idx_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every byte goes through the packer; the fourth byte of a word
        // parks the sequencer until the word has been taken.
        if (push) begin
            byte_pos_d = byte_pos_q + 6'd1;
            if (&byte_pos_q[1:0]) begin
                state_d = ST_WAITW;
                ret_d   = nxt;
            end else begin
                state_d = nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ret_q      <= ST_IDLE;
            byte_pos_q <= '0;
            word_idx_q <= '0;
            msg_len_q  <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            byte_pos_q <= byte_pos_d;
            word_idx_q <= word_idx_d;
            msg_len_q  <= msg_len_d;
            first_q    <= first_d;
            last_q     <= last_d;
            len_err_q  <= len_err_d;
        end
    end

    // in_ready is held low while reset is applied, even though IDLE accepts.
    assign bus.in_ready  = in_rdy & ~reset;
    assign bus.w_data    = w_data;
    assign bus.w_valid   = w_valid;
    assign bus.blk_first = first_q;
    assign bus.blk_last  = last_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.len_err   = len_err_q;

endmodule
